// File: rtl/bus_protocol_master_if.sv
// Byte-stream ports of bus_protocol_master: upstream valid/ready input and the dValid/dAck bus.
interface bus_protocol_master_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       dValid;
  logic       dAck;
  logic [7:0] data;

  modport master (
    input  in_valid,
    input  in_data,
    input  dAck,
    output in_ready,
    output dValid,
    output data
  );

  modport slave (
    output in_valid,
    output in_data,
    output dAck,
    input  in_ready,
    input  dValid,
    input  data
  );
endinterface

// File: rtl/bus_protocol_master.sv
// Transmit master for the dValid/dAck byte bus: buffers upstream bytes in a FIFO and
// sends each as one 2..4-cycle dValid window, flagging early acks and timeouts.
module bus_protocol_master #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_protocol_master_if.master bus,
  output logic                  xfer_done,
  output logic                  timeout_err,
  output logic                  early_ack_err,
  output logic [CW-1:0]         fifo_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  state_t          state;
  logic [CNTW-1:0] cnt;
  logic            dvalid_q;
  logic [7:0]      data_q;
  logic            ready_c;
  logic            push;
  logic            pop;

  // Readiness comes from the registered count only, never from in_valid.
  assign ready_c      = (fifo_count < CW'(DEPTH));
  assign push         = bus.in_valid && ready_c;
  assign pop          = (state == IDLE) && (fifo_count != '0);

  assign bus.in_ready = ready_c;
  assign bus.dValid   = dvalid_q;
  assign bus.data     = data_q;

  // Byte storage; entries are only read after being written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transfer sequencer: cnt is the index of the current dValid cycle (1..4).
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dvalid_q      <= 1'b0;
      data_q        <= 8'h00;
      xfer_done     <= 1'b0;
      timeout_err   <= 1'b0;
      early_ack_err <= 1'b0;
    end else begin
      xfer_done     <= 1'b0;
      timeout_err   <= 1'b0;
      early_ack_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            data_q   <= mem[rd_ptr];
            dvalid_q <= 1'b1;
            cnt      <= CNTW'(1);
            state    <= SEND;
          end
        end
        SEND: begin
          if (bus.dAck && (cnt == CNTW'(1))) begin
            // Target acked before it could have sampled the byte; keep driving.
            early_ack_err <= 1'b1;
            cnt           <= CNTW'(2);
          end else if (bus.dAck) begin
            dvalid_q  <= 1'b0;
            xfer_done <= 1'b1;
            state     <= IDLE;
          end else if (cnt == CNTW'(4)) begin
            dvalid_q    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus-rule invariants.
  assert property (@(posedge clk) disable iff (reset) !(xfer_done && timeout_err));
  assert property (@(posedge clk) disable iff (reset) !(xfer_done && early_ack_err));
  assert property (@(posedge clk) disable iff (reset)
                   dvalid_q |-> ((cnt != '0) && (cnt <= CNTW'(4))));

endmodule

// File: tb/tb_bus_protocol_master.sv
// Bench for bus_protocol_master: directed vector table, multi-cycle sequences and a
// randomized run against a queue-based transaction model.
module tb_bus_protocol_master;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          xfer_done;
  logic          timeout_err;
  logic          early_ack_err;
  logic [CW-1:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  bus_protocol_master_if bif ();

  bus_protocol_master #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bif),
    .xfer_done    (xfer_done),
    .timeout_err  (timeout_err),
    .early_ack_err(early_ack_err),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] id;
    logic       ak;
    logic       dv;
    logic [7:0] d;
    logic       done;
    logic       to;
    logic       ea;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic iv, input logic [7:0] id,
                              input logic ak, input logic dv, input logic [7:0] d,
                              input logic done, input logic to, input logic ea,
                              input int cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.ak = ak;
    v.dv = dv; v.d = d; v.done = done; v.to = to; v.ea = ea; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  // Reference model: queue of buffered bytes plus the age of the window on the bus.
  logic [7:0] mq[$];
  bit         m_busy;
  int         m_age;
  logic [7:0] m_data;
  bit         m_done;
  bit         m_to;
  bit         m_ea;

  function automatic void model_step(input bit rst, input bit iv, input logic [7:0] id,
                                     input bit ak);
    bit accept;
    m_done = 1'b0;
    m_to   = 1'b0;
    m_ea   = 1'b0;
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_age  = 0;
      m_data = 8'h00;
      return;
    end
    accept = iv && (mq.size() < int'(DEPTH));
    if (!m_busy) begin
      if (mq.size() != 0) begin
        m_data = mq.pop_front();
        m_busy = 1'b1;
        m_age  = 1;
      end
    end else begin
      // An ack only completes the transfer once the byte has been up for 2+ cycles.
      if (ak && m_age == 1) m_ea = 1'b1;
      if (ak && m_age >= 2) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end else if (m_age == 4) begin
        m_to   = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
    if (accept) mq.push_back(id);
  endfunction

  // Streams n bytes from base; a responsive target acks in dValid cycle ack_at (0 = never).
  task automatic stream(input string tag, input int n, input logic [7:0] base,
                        input int ack_at, input bit expect_stall);
    int         sent    = 0;
    int         seen    = 0;
    int         hi      = 0;
    int         lo      = 0;
    int         cyc     = 0;
    int         exp_len = (ack_at != 0) ? ack_at : 4;
    bit         stalled = 1'b0;
    bit         in_win  = 1'b0;
    bit         acc;
    logic [7:0] wdata   = 8'h00;
    while (seen < n && cyc < 300) begin
      if (bif.dValid) begin
        if (!in_win) begin
          in_win = 1'b1;
          hi     = 1;
          wdata  = bif.data;
          check($sformatf("%s byte%0d", tag, seen), 32'(bif.data), 32'(base + 8'(seen)));
          if (seen > 0) check($sformatf("%s gap%0d", tag, seen), 32'(lo), 32'd1);
        end else begin
          hi++;
          check($sformatf("%s stable%0d", tag, seen), 32'(bif.data), 32'(wdata));
        end
      end else begin
        if (in_win) begin
          in_win = 1'b0;
          check($sformatf("%s len%0d", tag, seen), 32'(hi), 32'(exp_len));
          check($sformatf("%s done%0d", tag, seen), 32'(xfer_done), 32'(ack_at != 0));
          check($sformatf("%s timeout%0d", tag, seen), 32'(timeout_err), 32'(ack_at == 0));
          check($sformatf("%s early%0d", tag, seen), 32'(early_ack_err), 32'd0);
          seen++;
          lo = 0;
        end
        lo++;
        if (seen > 0) check($sformatf("%s hold%0d", tag, seen), 32'(bif.data), 32'(wdata));
      end
      bif.in_valid = (sent < n);
      bif.in_data  = base + 8'(sent);
      bif.dAck     = in_win && (hi == ack_at);
      acc          = bif.in_valid && bif.in_ready;
      if (bif.in_valid && !bif.in_ready) begin
        stalled = 1'b1;
        check($sformatf("%s full_count", tag), 32'(fifo_count), 32'(DEPTH));
      end
      step();
      cyc++;
      if (acc) sent++;
    end
    bif.in_valid = 1'b0;
    bif.dAck     = 1'b0;
    check($sformatf("%s completed", tag), 32'(seen), 32'(n));
    check($sformatf("%s stall_seen", tag), 32'(stalled), 32'(expect_stall));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    bif.dAck     = 1'b0;

    //  rst iv  id    ak | dv  d     dn to ea cnt
    add(1, 0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 0);   // reset state
    add(0, 1, 8'hA5, 1,   0, 8'h00, 0, 0, 0, 1);   // push A5, idle ack ignored
    add(0, 0, 8'h00, 0,   1, 8'hA5, 0, 0, 0, 0);   // load
    add(0, 0, 8'h00, 0,   1, 8'hA5, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1,   0, 8'hA5, 1, 0, 0, 0);   // ack in cycle 2
    add(0, 0, 8'h00, 1,   0, 8'hA5, 0, 0, 0, 0);   // idle ack ignored
    add(0, 1, 8'h3C, 0,   0, 8'hA5, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0,   1, 8'h3C, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0,   1, 8'h3C, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0,   1, 8'h3C, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0,   1, 8'h3C, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1,   0, 8'h3C, 1, 0, 0, 0);   // ack in cycle 4
    add(0, 0, 8'h00, 0,   0, 8'h3C, 0, 0, 0, 0);
    add(0, 1, 8'h7E, 0,   0, 8'h3C, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0,   1, 8'h7E, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0,   1, 8'h7E, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0,   1, 8'h7E, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0,   1, 8'h7E, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0,   0, 8'h7E, 0, 1, 0, 0);   // timeout, byte dropped
    add(0, 0, 8'h00, 0,   0, 8'h7E, 0, 0, 0, 0);
    add(0, 1, 8'hC3, 0,   0, 8'h7E, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0,   1, 8'hC3, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1,   1, 8'hC3, 0, 0, 1, 0);   // early ack
    add(0, 0, 8'h00, 0,   1, 8'hC3, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1,   0, 8'hC3, 1, 0, 0, 0);   // ack in cycle 3
    add(0, 0, 8'h00, 0,   0, 8'hC3, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      reset        = tbl[i].rst;
      bif.in_valid = tbl[i].iv;
      bif.in_data  = tbl[i].id;
      bif.dAck     = tbl[i].ak;
      step();
      check($sformatf("row%0d dValid", i), 32'(bif.dValid), 32'(tbl[i].dv));
      check($sformatf("row%0d data", i), 32'(bif.data), 32'(tbl[i].d));
      check($sformatf("row%0d xfer_done", i), 32'(xfer_done), 32'(tbl[i].done));
      check($sformatf("row%0d timeout_err", i), 32'(timeout_err), 32'(tbl[i].to));
      check($sformatf("row%0d early_ack_err", i), 32'(early_ack_err), 32'(tbl[i].ea));
      check($sformatf("row%0d fifo_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
      check($sformatf("row%0d in_ready", i), 32'(bif.in_ready), 32'(tbl[i].cnt < int'(DEPTH)));
    end
    bif.in_valid = 1'b0;
    bif.dAck     = 1'b0;

    stream("burst_ack2", 5, 8'h01, 2, 1'b0);
    stream("burst_noack", 6, 8'h10, 0, 1'b1);

    // Reset in the 3rd dValid cycle with two bytes still buffered.
    bif.in_valid = 1'b1; bif.in_data = 8'h41; step();
    bif.in_data  = 8'h42; step();
    bif.in_data  = 8'h43; step();
    bif.in_valid = 1'b0; step();
    check("rst_mid dValid_before", 32'(bif.dValid), 32'd1);
    check("rst_mid count_before", 32'(fifo_count), 32'd2);
    check("rst_mid data_before", 32'(bif.data), 32'h41);
    reset = 1'b1; step();
    check("rst_mid dValid", 32'(bif.dValid), 32'd0);
    check("rst_mid count", 32'(fifo_count), 32'd0);
    check("rst_mid data", 32'(bif.data), 32'h00);
    check("rst_mid in_ready", 32'(bif.in_ready), 32'd1);
    check("rst_mid pulses", 32'({xfer_done, timeout_err, early_ack_err}), 32'd0);
    reset    = 1'b0;
    bif.dAck = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rst_quiet%0d dValid", k), 32'(bif.dValid), 32'd0);
      check($sformatf("rst_quiet%0d pulses", k),
            32'({xfer_done, timeout_err, early_ack_err}), 32'd0);
    end
    bif.dAck = 1'b0; bif.in_valid = 1'b1; bif.in_data = 8'h99; step();
    bif.in_valid = 1'b0;
    check("post_rst count", 32'(fifo_count), 32'd1);
    step();
    check("post_rst dValid", 32'(bif.dValid), 32'd1);
    check("post_rst data", 32'(bif.data), 32'h99);
    step();
    bif.dAck = 1'b1; step();
    bif.dAck = 1'b0;
    check("post_rst done", 32'(xfer_done), 32'd1);

    // Randomized run against the model, starting from a common reset.
    reset = 1'b1; step();
    model_step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      bit         r  = ($urandom_range(0, 199) == 0);
      bit         iv = bit'($urandom_range(0, 1));
      logic [7:0] id = 8'($urandom);
      bit         ak = ($urandom_range(0, 3) == 0);
      reset        = r;
      bif.in_valid = iv;
      bif.in_data  = id;
      bif.dAck     = ak;
      check("rnd in_ready", 32'(bif.in_ready), 32'(mq.size() < int'(DEPTH)));
      @(posedge clk);
      model_step(r, iv, id, ak);
      #1;
      check("rnd dValid", 32'(bif.dValid), 32'(m_busy));
      check("rnd data", 32'(bif.data), 32'(m_data));
      check("rnd xfer_done", 32'(xfer_done), 32'(m_done));
      check("rnd timeout_err", 32'(timeout_err), 32'(m_to));
      check("rnd early_ack_err", 32'(early_ack_err), 32'(m_ea));
      check("rnd fifo_count", 32'(fifo_count), 32'(mq.size()));
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
